peri_bus_bridge: RTL and testbench

- Sits directly downstream of the core wrapper's peripheral port: consumes rden/wren/addr/wdata/wstrb and returns gnt, ready and rdata.
- Decodes the address onto one of NUM_SLV peripheral slaves, holds the request until the slave acknowledges, and bounds every access with a timeout.
- Allows one outstanding access at a time. Unmapped or timed-out accesses complete with an error response, so the core never hangs.

---
 rtl/peri_bus_bridge.sv | 244 ++++++++++++++++++++++++
 tb/tb_peri_bus_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/peri_bus_bridge.sv
// -----------------------------------------------------------------------------
// peri_bus_bridge
//
// Purpose:
//    Bridges the core wrapper's peripheral port onto NUM_SLV peripheral slaves.
//    A request accepted in IDLE is decoded on a 4-bit slave-select field of the
//    address. It is then either issued to the selected slave and held until
//    that slave acknowledges, or failed at once when the address is unmapped.
//    Every issued access is bounded by a timeout so the core can never hang.
//    Only one access is outstanding at a time.
//
// Ports:
//    i_clk, i_rst_n       clock, synchronous active-low reset
//    i_peri_rden/wren     read / write request (sampled only while o_peri_gnt=1)
//    i_peri_addr/wdata    byte address and write data
//    i_peri_wstrb         byte strobes
//    o_peri_gnt           bridge is idle and accepts a request this cycle
//    o_peri_ready         one-cycle completion pulse
//    o_peri_rdata         read data, valid with o_peri_ready, held afterwards
//    o_slv_req            one-hot slave request, held until the slave is ready
//    o_slv_we             latched write flag
//    o_slv_addr/wdata     latched address and write data
//    o_slv_wstrb          latched byte strobes
//    i_slv_ready          per-slave completion
//    i_slv_rdata          per-slave read data, slave k at [32k+31:32k]
//    o_err                error flag, pulses together with o_peri_ready
//    o_err_cnt            saturating count of failed accesses
// -----------------------------------------------------------------------------
module peri_bus_bridge #(
   parameter int unsigned NUM_SLV   = 4,
   parameter int unsigned SEL_LSB   = 24,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_peri_rden,
   input  logic                    i_peri_wren,
   input  logic [31:0]             i_peri_addr,
   input  logic [31:0]             i_peri_wdata,
   input  logic [3:0]              i_peri_wstrb,
   output logic                    o_peri_gnt,
   output logic                    o_peri_ready,
   output logic [31:0]             o_peri_rdata,
   output logic [NUM_SLV-1:0]      o_slv_req,
   output logic                    o_slv_we,
   output logic [31:0]             o_slv_addr,
   output logic [31:0]             o_slv_wdata,
   output logic [3:0]              o_slv_wstrb,
   input  logic [NUM_SLV-1:0]      i_slv_ready,
   input  logic [32*NUM_SLV-1:0]   i_slv_rdata,
   output logic                    o_err,
   output logic [15:0]             o_err_cnt
);

   // Last counter value allowed in WAIT; the access times out on that cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t               state_q,     state_d;
   logic                 gnt_q,       gnt_d;
   logic                 ready_q,     ready_d;
   logic [31:0]          rdata_q,     rdata_d;
   logic [NUM_SLV-1:0]   slv_req_q,   slv_req_d;
   logic                 slv_we_q,    slv_we_d;
   logic [31:0]          slv_addr_q,  slv_addr_d;
   logic [31:0]          slv_wdata_q, slv_wdata_d;
   logic [3:0]           slv_wstrb_q, slv_wstrb_d;
   logic                 err_q,       err_d;
   logic [15:0]          err_cnt_q,   err_cnt_d;
   logic [15:0]          tmo_cnt_q,   tmo_cnt_d;

   // Address decode results for the request currently on the peripheral port.
   logic [NUM_SLV-1:0]   dec_onehot;
   logic                 dec_mapped;

   // Response side, qualified by the held one-hot request so that a ready
   // from any non-selected slave is ignored without indexing by select value.
   logic                 slv_hit;
   logic [31:0]          slv_rdata_sel;

   // --------------------------------------------------------------------------
   // Address decode: one-hot select of the 4-bit field. A select value at or
   // above NUM_SLV leaves the vector all-zero, which marks the access unmapped,
   // as does a zero top nibble.
   // --------------------------------------------------------------------------
   always_comb begin
      dec_onehot = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (i_peri_addr[SEL_LSB +: 4] == 4'(k)) begin
            dec_onehot[k] = 1'b1;
         end
      end
   end

   assign dec_mapped = (i_peri_addr[31:28] != 4'h0) && (dec_onehot != '0);

   // --------------------------------------------------------------------------
   // Response select: AND-OR mux over the slaves, steered by the held request.
   // --------------------------------------------------------------------------
   always_comb begin
      slv_hit       = |(i_slv_ready & slv_req_q);
      slv_rdata_sel = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (slv_req_q[k]) begin
            slv_rdata_sel = slv_rdata_sel | i_slv_rdata[32*k +: 32];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic. All outputs are registered: each *_d holds the value
   // the output takes in the cycle after the current edge.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every *_d gets a default before the case so that no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      slv_req_d   = slv_req_q;
      slv_we_d    = slv_we_q;
      slv_addr_d  = slv_addr_q;
      slv_wdata_d = slv_wdata_q;
      slv_wstrb_d = slv_wstrb_q;
      err_cnt_d   = err_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_peri_rden || i_peri_wren) begin
               // A simultaneous read and write request is treated as a write.
               slv_we_d    = i_peri_wren;
               slv_addr_d  = i_peri_addr;
               slv_wdata_d = i_peri_wdata;
               slv_wstrb_d = i_peri_wstrb;
               if (dec_mapped) begin
                  state_d   = ST_WAIT;
                  slv_req_d = dec_onehot;
               end else begin
                  // Unmapped: skip the slave entirely and fail immediately.
                  state_d = ST_RESP;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end

         ST_WAIT: begin
            // Slave ready is tested first so it wins over a same-cycle timeout.
            if (slv_hit) begin
               state_d   = ST_RESP;
               ready_d   = 1'b1;
               rdata_d   = slv_we_q ? 32'h0 : slv_rdata_sel;
               slv_req_d = '0;
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = ST_RESP;
               ready_d   = 1'b1;
               err_d     = 1'b1;
               rdata_d   = slv_we_q ? 32'h0 : ERR_RDATA;
               slv_req_d = '0;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end

         ST_RESP: begin
            // err_q is the error flag of the access completing this cycle.
            state_d   = ST_IDLE;
            tmo_cnt_d = '0;
            if (err_q && (err_cnt_q != 16'hFFFF)) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            slv_req_d = '0;
            tmo_cnt_d = '0;
         end
      endcase

      // Grant is exactly "next state is IDLE", registered alongside the state.
      gnt_d = (state_d == ST_IDLE);
   end

   // --------------------------------------------------------------------------
   // State and output registers.
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      // NOTE: the latched slave-side datapath is reset as well, not only the
      // control state, so the slave bus shows defined zeros out of reset.
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 1'b1;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         slv_req_q   <= '0;
         slv_we_q    <= 1'b0;
         slv_addr_q  <= '0;
         slv_wdata_q <= '0;
         slv_wstrb_q <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         slv_req_q   <= slv_req_d;
         slv_we_q    <= slv_we_d;
         slv_addr_q  <= slv_addr_d;
         slv_wdata_q <= slv_wdata_d;
         slv_wstrb_q <= slv_wstrb_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign o_peri_gnt   = gnt_q;
   assign o_peri_ready = ready_q;
   assign o_peri_rdata = rdata_q;
   assign o_slv_req    = slv_req_q;
   assign o_slv_we     = slv_we_q;
   assign o_slv_addr   = slv_addr_q;
   assign o_slv_wdata  = slv_wdata_q;
   assign o_slv_wstrb  = slv_wstrb_q;
   assign o_err        = err_q;
   assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_peri_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_peri_bus_bridge
//
// Self-checking bench for peri_bus_bridge (NUM_SLV=4, TIMEOUT=8). Each access
// is predicted from the bridge's rules: decode to mapped/unmapped, then the
// completion cycle, read data and error flag follow from the slave's response
// delay. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_peri_bus_bridge;

   localparam int          NUM_SLV   = 4;
   localparam int          SEL_LSB   = 24;
   localparam int          TIMEOUT   = 8;
   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   rden;
   logic                   wren;
   logic [31:0]            addr;
   logic [31:0]            wdata;
   logic [3:0]             wstrb;
   logic                   gnt;
   logic                   ready;
   logic [31:0]            rdata;
   logic [NUM_SLV-1:0]     slv_req;
   logic                   slv_we;
   logic [31:0]            slv_addr;
   logic [31:0]            slv_wdata;
   logic [3:0]             slv_wstrb;
   logic [NUM_SLV-1:0]     slv_ready;
   logic [32*NUM_SLV-1:0]  slv_rdata;
   logic                   err;
   logic [15:0]            err_cnt;

   int checks = 0;
   int errors = 0;
   int model_err_cnt = 0;

   always #5 clk = ~clk;

   peri_bus_bridge #(
      .NUM_SLV   (NUM_SLV),
      .SEL_LSB   (SEL_LSB),
      .TIMEOUT   (TIMEOUT),
      .ERR_RDATA (ERR_RDATA)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_peri_rden  (rden),
      .i_peri_wren  (wren),
      .i_peri_addr  (addr),
      .i_peri_wdata (wdata),
      .i_peri_wstrb (wstrb),
      .o_peri_gnt   (gnt),
      .o_peri_ready (ready),
      .o_peri_rdata (rdata),
      .o_slv_req    (slv_req),
      .o_slv_we     (slv_we),
      .o_slv_addr   (slv_addr),
      .o_slv_wdata  (slv_wdata),
      .o_slv_wstrb  (slv_wstrb),
      .i_slv_ready  (slv_ready),
      .i_slv_rdata  (slv_rdata),
      .o_err        (err),
      .o_err_cnt    (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One complete access. Called right after a falling edge with the bridge
   // idle; returns right after the falling edge of the first idle cycle that
   // follows, so consecutive calls run back-to-back.
   // dly: cycles after the request first appears before the slave answers;
   // negative (or >= TIMEOUT) means the slave stays silent.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input int dly_in, input logic [31:0] sdata, input bit noise);
      logic [3:0]         sel;
      bit                 mapped;
      int                 dly;
      int                 lat;
      logic [31:0]        exp_rdata;
      bit                 exp_err;
      logic [NUM_SLV-1:0] one;
      logic [NUM_SLV-1:0] onehot;
      logic [31:0]        rnd;

      sel    = a[SEL_LSB +: 4];
      mapped = (a[31:28] != 4'h0) && (int'(sel) < NUM_SLV);
      dly    = (dly_in >= TIMEOUT) ? -1 : dly_in;
      one    = 1;
      onehot = mapped ? (one << sel) : '0;

      if (!mapped) begin
         lat = 1;            exp_rdata = 32'h0;                  exp_err = 1'b1;
      end else if (dly >= 0) begin
         lat = dly + 2;      exp_rdata = wr ? 32'h0 : sdata;     exp_err = 1'b0;
      end else begin
         lat = TIMEOUT + 1;  exp_rdata = wr ? 32'h0 : ERR_RDATA; exp_err = 1'b1;
      end
      if (exp_err && model_err_cnt < 65535) model_err_cnt++;

      check("gnt_before", 32'(gnt), 32'd1);
      rden  = rd;
      wren  = wr;
      addr  = a;
      wdata = wd;
      wstrb = ws;
      for (int s = 0; s < NUM_SLV; s++) slv_rdata[32*s +: 32] = $urandom;
      if (mapped) slv_rdata[32*int'(sel) +: 32] = sdata;

      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         check("ready", 32'(ready), 32'(k == lat));
         check("slv_req", 32'(slv_req), (k < lat) ? 32'(onehot) : 32'h0);
         check("gnt_busy", 32'(gnt), 32'd0);
         if (mapped && k < lat) begin
            check("slv_we", 32'(slv_we), 32'(wr));
            check("slv_addr", slv_addr, a);
            check("slv_wdata", slv_wdata, wd);
            check("slv_wstrb", 32'(slv_wstrb), 32'(ws));
         end
         if (k == lat) begin
            check("rdata", rdata, exp_rdata);
            check("err", 32'(err), 32'(exp_err));
         end else begin
            check("err_quiet", 32'(err), 32'd0);
         end
         // Garbage on the request port while busy must be ignored.
         rnd   = $urandom;
         rden  = (k < lat) & rnd[0];
         wren  = (k < lat) & rnd[1];
         addr  = $urandom;
         wdata = $urandom;
         wstrb = rnd[7:4];
         slv_ready = noise ? (rnd[8 +: NUM_SLV] & ~onehot) : '0;
         if (mapped && dly >= 0 && k == dly + 1) slv_ready = slv_ready | onehot;
      end

      @(negedge clk);
      check("gnt_after", 32'(gnt), 32'd1);
      check("ready_after", 32'(ready), 32'd0);
      check("rdata_hold", rdata, exp_rdata);
      check("slv_req_after", 32'(slv_req), 32'h0);
      check("err_cnt", 32'(err_cnt), 32'(model_err_cnt));
      slv_ready = '0;
      rden      = 1'b0;
      wren      = 1'b0;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] r;
      int          op;

      rst_n     = 1'b0;
      rden      = 1'b0;
      wren      = 1'b0;
      addr      = '0;
      wdata     = '0;
      wstrb     = '0;
      slv_ready = '0;
      slv_rdata = '0;
      repeat (3) @(negedge clk);

      check("rst_gnt", 32'(gnt), 32'd1);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_slv_req", 32'(slv_req), 32'h0);
      check("rst_slv_we", 32'(slv_we), 32'd0);
      check("rst_slv_addr", slv_addr, 32'h0);
      check("rst_slv_wdata", slv_wdata, 32'h0);
      check("rst_slv_wstrb", 32'(slv_wstrb), 32'h0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Read slave 1, immediate ready.
      run_access(1'b1, 1'b0, 32'h1100_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0);
      // Write slave 2, ready after 5 cycles.
      run_access(1'b0, 1'b1, 32'h2200_0000, 32'hA5A5_A5A5, 4'b0011, 5, 32'hFFFF_0000, 1'b0);
      // Read slave 3, silent: timeout.
      run_access(1'b1, 1'b0, 32'h1300_0000, 32'h0, 4'hF, -1, 32'h0BAD_F00D, 1'b0);
      // Unmapped: zero top nibble, then select beyond NUM_SLV.
      run_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 32'h1111_1111, 1'b0);
      run_access(1'b0, 1'b1, 32'h3500_0000, 32'h5555_AAAA, 4'hF, 0, 32'h2222_2222, 1'b1);
      // Ready on the timeout cycle wins; other slaves toggle ready meanwhile.
      run_access(1'b1, 1'b0, 32'h4000_0100, 32'h0, 4'hF, TIMEOUT - 1, 32'hCAFE_0001, 1'b1);
      // Silent write: error with zero read data.
      run_access(1'b0, 1'b1, 32'h7100_0004, 32'h0123_4567, 4'b1000, -1, 32'h9999_9999, 1'b1);
      // Read and write together: treated as a write.
      run_access(1'b1, 1'b1, 32'hF300_0020, 32'h0F0F_0F0F, 4'b0101, 2, 32'h7777_7777, 1'b1);

      for (int i = 0; i < 40; i++) begin
         r  = $urandom;
         ra = $urandom;
         ra[31:28] = (r[2:0] == 3'd0) ? 4'h0 : 4'($urandom_range(1, 15));
         ra[27:24] = 4'($urandom_range(0, 5));
         op = $urandom_range(0, 2);
         run_access(op != 1, op != 0, ra, $urandom, r[7:4],
                    $urandom_range(0, 10) - 1, $urandom, r[8]);
      end

      // Reset during WAIT abandons the access and clears the error count.
      rden = 1'b1;
      wren = 1'b0;
      addr = 32'h1000_0040;
      @(negedge clk);
      check("rw_req", 32'(slv_req), 32'h1);
      rden  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_err_cnt = 0;
      check("rw_req_drop", 32'(slv_req), 32'h0);
      check("rw_gnt", 32'(gnt), 32'd1);
      check("rw_ready", 32'(ready), 32'd0);
      check("rw_err_cnt", 32'(err_cnt), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rw_no_ready", 32'(ready), 32'd0);
         check("rw_idle_req", 32'(slv_req), 32'h0);
      end
      run_access(1'b1, 1'b0, 32'h1200_0008, 32'h0, 4'hF, 1, 32'h600D_DA7A, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
